mdu: RTL
========

# mdu

Multi-cycle multiply/divide unit for the RV64 execute stage. It is the responder side of the execute-stage long-operation interface: the execute stage issues M-extension operations over a valid/ready request channel and collects the 64-bit result over a valid/ready response channel. It runs alongside the single-cycle ALU and handles the operations that do not fit in one cycle: shift-add multiply and restoring divide, one bit per cycle.

## Interface
- No parameters; the datapath is fixed at 64 bits (`u64`).
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: abandon any in-flight operation; sampled on the rising edge of `clk`.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_op` in `mdu_op_t`: one of MUL, DIV, DIVU, REM, REMU.
- `req_word` in 1: selects the W variant (MULW, DIVW, DIVUW, REMW, REMUW).
- `req_a`, `req_b` in 64: operands. `a` is the multiplicand or dividend.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out 64: result.

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - BUSY: iterating.
  - DONE: `resp_valid`=1.
- **Accept:**
  - A request is accepted on the edge where `req_valid && req_ready` and `flush`=0.
  - On accept, latch operands, op and word flag, then compute sign/magnitude.
- **Iteration count:**
  - N=64 for 64-bit ops, N=32 for W ops.
  - The counter is loaded with N on accept and decremented once per BUSY cycle.
  - BUSY moves to DONE on the edge where the counter goes 1→0.
- **MUL/MULW:**
  - Unsigned shift-add on operand magnitudes.
  - Result is the low 64 bits. For MULW, the low 32 bits are taken and sign-extended.
  - Low bits do not depend on signedness.
- **DIV/REM (signed):**
  - Divide the magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
- **DIVU/REMU:** operands are used as-is.
- **W variants:**
  - Operands are the low 32 bits, sign- or zero-extended per op.
  - The 32-bit result is sign-extended to 64 bits, including DIVUW and REMUW.
- **Special cases** skip BUSY and go IDLE→DONE on the accept edge:
  - Divide by zero (the effective divisor is 0): quotient = all ones; remainder = effective dividend, sign-extended for W.
  - Signed overflow (`a`=most-negative, `b`=−1 at the effective width): quotient = `a`, sign-extended for W; remainder = 0.
- **Leaving DONE:**
  - DONE→IDLE on the edge where `resp_ready`=1.
  - `resp_data` is held stable while `resp_valid`=1.
- **flush:**
  - From any state, the next state is IDLE and `resp_valid` drops on that edge.
  - `flush` beats accept: a request offered in a flush cycle is not accepted.
- **Reset** (asynchronous, any state): state=IDLE, counter=0, `resp_valid`=0, `resp_data`=0, internal registers=0. The in-flight op is lost.

## Timing
- `req_ready` is decoded from the state only: 1 iff IDLE, so it reads 1 during reset.
- It does not depend combinationally on `req_valid`.
- `resp_valid`=1 iff DONE (registered).
- **Normal-op latency:** accept on edge k → `resp_valid` rises after edge k+N (65 cycles for 64-bit ops, 33 cycles for W ops, counted from the request cycle).
- **Special-case latency:** `resp_valid` rises after edge k.
- There is no back-to-back issue. Earliest next accept is on the edge after the `resp_ready` handshake edge, since `req_ready`=0 in DONE.
- `resp_ready` is ignored outside DONE. `req_*` inputs are ignored outside IDLE.

## Structure
- `mdu_op_t` (3-bit enum: MUL, DIV, DIVU, REM, REMU) goes in `pipes`, next to `alufunc_t`.
- The state enum is local to the module.
- Sign/extend helpers (`sext32`, magnitude, conditional negate) go in `common` as functions.
- The block is a single module. The shift-add and restoring-divide datapaths share one 128-bit accumulator/partial-remainder register plus one 64-bit operand register; no sub-module is needed.

## Test plan
- **MUL:** a=7, b=−3 (0xFFFF_FFFF_FFFF_FFFD), `resp_ready`=1 → `resp_data`=0xFFFF_FFFF_FFFF_FFEB; `resp_valid` rises exactly 65 cycles after the request cycle.
- **DIV/REM/DIVU:**
  - DIV a=−7, b=2 → 0xFFFF_FFFF_FFFF_FFFD.
  - REM a=−7, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVU a=100, b=7 → 14.
  - Each takes 65 cycles.
- **Divide by zero and overflow:**
  - DIVU a=5, b=0 → all ones.
  - REM a=5, b=0 → 5.
  - DIV a=0x8000_0000_0000_0000, b=−1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
  - All complete 1 cycle after accept.
- **W ops:**
  - DIVUW a=0xFFFF_FFFF_8000_0000, b=1 → 0xFFFF_FFFF_8000_0000.
  - MULW a=0x1_0000_0002, b=0x4000_0000 → 0xFFFF_FFFF_8000_0000.
  - Both have 33-cycle latency.
- **Response backpressure:** hold `resp_ready`=0 for 10 cycles in DONE → `resp_valid` and `resp_data` are stable and `req_ready`=0. Raise `resp_ready` → IDLE next edge. A new request is accepted the edge after.
- **flush and reset mid-operation:**
  - Assert `flush` at cycle 20 of a 64-bit DIV → `resp_valid` never rises, `req_ready`=1 next cycle.
  - A following MUL 3×4 returns 12.
  - Pulse `resetn` low mid-BUSY → immediate IDLE and `resp_data`=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and sign/extend helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL  = 3'd0,
    MDU_DIV  = 3'd1,
    MDU_DIVU = 3'd2,
    MDU_REM  = 3'd3,
    MDU_REMU = 3'd4
  } mdu_op_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] cneg(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [63:0] magnitude(input logic [63:0] v, input logic sgn);
    return cneg(v, sgn & v[63]);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle RV64 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, sharing a 128-bit accumulator and a 64-bit operand register.
module mdu
  import mdu_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  mdu_op_t       req_op,
  input  logic          req_word,
  input  logic [63:0]   req_a,
  input  logic [63:0]   req_b,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [63:0]   resp_data
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready=1
  // BUSY   | iterating one bit per cycle
  // DONE   | result held on resp_data, resp_valid=1
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state;
  logic [6:0]   cnt;
  logic [127:0] acc;
  logic [63:0]  opb;
  mdu_op_t      op;
  logic         word;
  logic         neg_res;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);

  logic        in_mul, in_quot, in_signed;
  logic        na, nb, in_neg, div_zero, div_ovf;
  logic [63:0] ea, eb, ma, mb, spec_res;

  always_comb begin
    in_mul    = (req_op == MDU_MUL);
    in_quot   = (req_op == MDU_DIV) || (req_op == MDU_DIVU);
    in_signed = (req_op == MDU_MUL) || (req_op == MDU_DIV) || (req_op == MDU_REM);
    if (req_word) begin
      ea = in_signed ? sext32(req_a[31:0]) : {32'd0, req_a[31:0]};
      eb = in_signed ? sext32(req_b[31:0]) : {32'd0, req_b[31:0]};
    end else begin
      ea = req_a;
      eb = req_b;
    end
    na       = in_signed & ea[63];
    nb       = in_signed & eb[63];
    ma       = magnitude(ea, in_signed);
    mb       = magnitude(eb, in_signed);
    div_zero = !in_mul && (eb == 64'd0);
    div_ovf  = !in_mul && in_signed && (eb == {64{1'b1}}) &&
               (ea == (req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (in_mul || req_op == MDU_DIV) in_neg = na ^ nb;
    else if (req_op == MDU_REM)      in_neg = na;
    else                             in_neg = 1'b0;
    // ea is already extended to 64 bits, so the overflow quotient needs no fixup
    if (div_zero)     spec_res = in_quot ? {64{1'b1}} : (req_word ? sext32(ea[31:0]) : ea);
    else if (in_quot) spec_res = ea;
    else              spec_res = 64'd0;
  end

  logic [64:0]  rem_sh;
  logic         rem_ge;
  logic [127:0] acc_nxt;
  logic [63:0]  opb_nxt, raw, fixed, res;

  always_comb begin
    acc_nxt = acc;
    opb_nxt = opb;
    rem_sh  = acc[127:63];
    rem_ge  = rem_sh >= {1'b0, opb};
    if (op == MDU_MUL) begin
      // multiplier in the upper half shifts right, multiplicand shifts left
      acc_nxt[127:64] = {1'b0, acc[127:65]};
      acc_nxt[63:0]   = acc[64] ? acc[63:0] + opb : acc[63:0];
      opb_nxt         = {opb[62:0], 1'b0};
    end else begin
      acc_nxt[127:64] = rem_ge ? (rem_sh[63:0] - opb) : rem_sh[63:0];
      acc_nxt[63:0]   = {acc[62:0], rem_ge};
    end
    if (op == MDU_REM || op == MDU_REMU) raw = acc_nxt[127:64];
    else                                 raw = acc_nxt[63:0];
    fixed = cneg(raw, neg_res);
    res   = word ? sext32(fixed[31:0]) : fixed;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= 7'd0;
      acc       <= 128'd0;
      opb       <= 64'd0;
      op        <= MDU_MUL;
      word      <= 1'b0;
      neg_res   <= 1'b0;
      resp_data <= 64'd0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op      <= req_op;
            word    <= req_word;
            neg_res <= in_neg;
            cnt     <= req_word ? 7'd32 : 7'd64;
            if (div_zero || div_ovf) begin
              resp_data <= spec_res;
              state     <= S_DONE;
            end else begin
              state <= S_BUSY;
              if (in_mul) begin
                acc <= {mb, 64'd0};
                opb <= ma;
              end else begin
                // W dividends are pre-aligned so 32 steps consume their bits
                acc <= {64'd0, req_word ? {ma[31:0], 32'd0} : ma};
                opb <= mb;
              end
            end
          end
        end
        S_BUSY: begin
          acc <= acc_nxt;
          opb <= opb_nxt;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            resp_data <= res;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
